// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory port bundle for the load/store unit.
// The master side is the CPU plus memory environment; the slave side is the unit itself.
interface load_store_unit_if #(
  parameter int data_size = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [data_size-1:0] req_addr;
  logic [data_size-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_err;
  logic [data_size-1:0] resp_rdata;
  logic                 mem_write_en;
  logic [data_size-1:0] mem_addr;
  logic [data_size-1:0] mem_write_data;
  logic [data_size-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_write_en, mem_addr, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_write_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word CPU accesses mapped onto a word-addressed memory,
// with sign/zero-extended loads and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int data_size = 32,
  parameter int mem_words = 1024
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, READ, LOAD_DATA, WRITE, RMW_READ, RMW_MERGE
  } state_t;

  localparam logic [data_size-1:0] mem_limit = data_size'(mem_words);

  state_t               state_reg, state_next;
  logic [data_size-1:0] addr_reg, wdata_reg;
  logic [1:0]           size_reg;
  logic                 unsigned_reg, write_reg;
  logic                 resp_valid_reg, resp_valid_next;
  logic                 resp_err_reg, resp_err_next;
  logic [data_size-1:0] resp_rdata_reg, resp_rdata_next;

  logic                 accept, req_err;
  logic [4:0]           lane_shift;
  logic [data_size-1:0] word_addr, rdata_shifted, load_ext, lane_mask, merged;
  logic                 mem_write_en_next;
  logic [data_size-1:0] mem_addr_next, mem_write_data_next;

  assign accept = bus.req_valid && (state_reg == IDLE);

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b11:   req_err = 1'b1;
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = |bus.req_addr[1:0];
      default: req_err = 1'b0;
    endcase
    if ({2'b00, bus.req_addr[data_size-1:2]} >= mem_limit) req_err = 1'b1;
  end

  // A half access is always 2-aligned here, so one byte-granular shift serves both sizes.
  assign word_addr     = {2'b00, addr_reg[data_size-1:2]};
  assign lane_shift    = {addr_reg[1:0], 3'b000};
  assign rdata_shifted = bus.mem_rdata >> lane_shift;

  always_comb begin
    case (size_reg)
      2'b00:   load_ext = {{24{~unsigned_reg & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_ext = {{16{~unsigned_reg & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  assign lane_mask = ((size_reg == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shift;
  assign merged    = (bus.mem_rdata & ~lane_mask) | ((wdata_reg << lane_shift) & lane_mask);

  always_comb begin
    state_next          = state_reg;
    resp_valid_next     = 1'b0;
    resp_err_next       = 1'b0;
    resp_rdata_next     = '0;
    mem_write_en_next   = 1'b0;
    mem_addr_next       = '0;
    mem_write_data_next = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else if (!bus.req_write) begin
            state_next = READ;
          end else if (bus.req_size == 2'b10) begin
            state_next = WRITE;
          end else begin
            state_next = RMW_READ;
          end
        end
      end
      READ: begin
        mem_addr_next = word_addr;
        state_next    = LOAD_DATA;
      end
      LOAD_DATA: begin
        mem_addr_next   = word_addr;
        resp_valid_next = 1'b1;
        resp_rdata_next = load_ext;
        state_next      = IDLE;
      end
      WRITE: begin
        mem_addr_next       = word_addr;
        mem_write_en_next   = 1'b1;
        mem_write_data_next = wdata_reg;
        resp_valid_next     = 1'b1;
        state_next          = IDLE;
      end
      RMW_READ: begin
        mem_addr_next = word_addr;
        state_next    = RMW_MERGE;
      end
      RMW_MERGE: begin
        mem_addr_next       = word_addr;
        mem_write_en_next   = 1'b1;
        mem_write_data_next = merged;
        resp_valid_next     = 1'b1;
        state_next          = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      size_reg       <= '0;
      unsigned_reg   <= 1'b0;
      write_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      if (accept) begin
        addr_reg     <= bus.req_addr;
        wdata_reg    <= bus.req_wdata;
        size_reg     <= bus.req_size;
        unsigned_reg <= bus.req_unsigned;
        write_reg    <= bus.req_write;
      end
    end
  end

  assign bus.req_ready      = (state_reg == IDLE);
  assign bus.resp_valid     = resp_valid_reg;
  assign bus.resp_err       = resp_err_reg;
  assign bus.resp_rdata     = resp_rdata_reg;
  assign bus.mem_write_en   = mem_write_en_next;
  assign bus.mem_addr       = mem_addr_next;
  assign bus.mem_write_data = mem_write_data_next;

  // write_reg is only needed at acceptance; it is kept for debug visibility.
  logic unused_ok;
  assign unused_ok = write_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan cases, reset abort,
// back-to-back loads and randomized traffic against a byte-array reference model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.data_size(32), .mem_words(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory: synchronous read, one-cycle latency.
  logic [31:0] mem_arr [0:1023];
  always @(posedge clk) begin
    if (bus.mem_write_en) mem_arr[bus.mem_addr[9:0]] <= bus.mem_write_data;
    bus.mem_rdata <= mem_arr[bus.mem_addr[9:0]];
  end

  // Reference model: memory seen as 4096 little-endian bytes.
  logic [7:0] ref_bytes [0:4095];

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] last_rdata, last_we_addr, last_we_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic set_word(input int w, input logic [31:0] v);
    mem_arr[w] = v;
    for (int i = 0; i < 4; i++) ref_bytes[4*w+i] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
           (sz == 2'b10 && a % 4 != 0) || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_bytes[int'(a) + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
  endtask

  // One request; observes cycles 1..6 after the acceptance edge.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic        exp_err, got_err, ready_c1;
    logic [31:0] exp_rdata;
    int resp_cyc, resp_cnt, we_cyc, we_cnt, exp_resp_cyc, exp_we_cyc, exp_we_cnt;
    exp_err = model_err(sz, addr);
    @(negedge clk);
    check("ready_before_req", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    resp_cyc = 0; resp_cnt = 0; we_cyc = 0; we_cnt = 0;
    got_err = 1'b0; last_rdata = 32'hDEAD_BEEF; ready_c1 = bus.req_ready;
    for (int c = 1; c <= 6; c++) begin
      if (bus.mem_write_en) begin
        we_cnt++; we_cyc = c;
        last_we_addr = bus.mem_addr; last_we_data = bus.mem_write_data;
      end
      if (bus.resp_valid) begin
        resp_cnt++;
        if (resp_cyc == 0) begin
          resp_cyc = c; got_err = bus.resp_err; last_rdata = bus.resp_rdata;
        end
      end
      if (c < 6) begin
        @(posedge clk);
        #1;
      end
    end
    if (exp_err) begin
      exp_resp_cyc = 1; exp_we_cnt = 0; exp_we_cyc = 0; exp_rdata = 0;
      check("err_ready_stays", 32'(ready_c1), 32'd1);
    end else if (!wr) begin
      exp_resp_cyc = 3; exp_we_cnt = 0; exp_we_cyc = 0;
      exp_rdata = model_load(sz, uns, addr);
    end else begin
      exp_we_cyc = (sz == 2'b10) ? 1 : 2;
      exp_resp_cyc = exp_we_cyc + 1; exp_we_cnt = 1; exp_rdata = 0;
      model_store(sz, addr, wd);
      check("we_addr", last_we_addr, addr >> 2);
      check("we_data", last_we_data, model_word(int'(addr >> 2)));
    end
    check("resp_cycle", 32'(resp_cyc), 32'(exp_resp_cyc));
    check("resp_count", 32'(resp_cnt), 32'd1);
    check("resp_err", 32'(got_err), 32'(exp_err));
    check("resp_rdata", last_rdata, exp_rdata);
    check("we_count", 32'(we_cnt), 32'(exp_we_cnt));
    check("we_cycle", 32'(we_cyc), 32'(exp_we_cyc));
    $display("txn wr=%0d size=%0d uns=%0d addr=%08h wdata=%08h -> err=%0d rdata=%08h resp_cyc=%0d",
             wr, sz, uns, addr, wd, got_err, last_rdata, resp_cyc);
  endtask

  task automatic reset_abort_test();
    logic resp_seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h14; bus.req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_we_low", 32'(bus.mem_write_en), 32'd0);
    resp_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      resp_seen = resp_seen | bus.resp_valid | bus.mem_write_en;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    resp_seen = resp_seen | bus.resp_valid;
    check("rst_no_resp", 32'(resp_seen), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_word5_kept", mem_arr[5], model_word(5));
    $display("txn reset-abort half store 0xBEEF @0x14 -> word5=%08h", mem_arr[5]);
  endtask

  task automatic b2b_test();
    logic [1:0]  sz [3];
    logic        un [3];
    logic [31:0] ad [3];
    logic [31:0] ex [3];
    int acc_cyc [3];
    int n_acc, n_resp;
    logic ready_before;
    sz[0] = 2'b10; un[0] = 1'b0; ad[0] = 32'h08;
    sz[1] = 2'b00; un[1] = 1'b0; ad[1] = 32'h17;
    sz[2] = 2'b01; un[2] = 1'b1; ad[2] = 32'h16;
    for (int i = 0; i < 3; i++) ex[i] = model_load(sz[i], un[i], ad[i]);
    n_acc = 0; n_resp = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_size = sz[0]; bus.req_unsigned = un[0]; bus.req_addr = ad[0];
    ready_before = bus.req_ready;
    for (int c = 0; c < 20 && n_resp < 3; c++) begin
      @(posedge clk);
      #1;
      if (ready_before && bus.req_valid && n_acc < 3) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc < 3) begin
          bus.req_size = sz[n_acc]; bus.req_unsigned = un[n_acc]; bus.req_addr = ad[n_acc];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      if (bus.resp_valid && n_resp < 3) begin
        check("b2b_rdata", bus.resp_rdata, ex[n_resp]);
        check("b2b_ready_with_resp", 32'(bus.req_ready), 32'd1);
        $display("txn b2b load %0d addr=%08h -> rdata=%08h", n_resp, ad[n_resp], bus.resp_rdata);
        n_resp++;
      end
      ready_before = bus.req_ready;
    end
    bus.req_valid = 1'b0;
    check("b2b_resp_total", 32'(n_resp), 32'd3);
    check("b2b_accepts", 32'(n_acc), 32'd3);
    if (n_acc == 3) begin
      check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int r;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int w = 0; w < 1024; w++) set_word(w, $urandom);
    set_word(5, 32'h8844_22F0);
    #2;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mem_we", 32'(bus.mem_write_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b0, 2'b00, 1'b0, 32'h14, 0);
    check("tp_lb_signed", last_rdata, 32'hFFFF_FFF0);
    do_req(1'b0, 2'b00, 1'b1, 32'h17, 0);
    check("tp_lbu", last_rdata, 32'h0000_0088);
    do_req(1'b0, 2'b01, 1'b0, 32'h16, 0);
    check("tp_lh_signed", last_rdata, 32'hFFFF_8844);
    do_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_00AB);
    check("tp_sb_addr", last_we_addr, 32'd5);
    check("tp_sb_data", last_we_data, 32'h8844_ABF0);
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 0);
    check("tp_sb_readback", last_rdata, 32'h8844_ABF0);
    do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h1234_5678);
    check("tp_sw_addr", last_we_addr, 32'd2);
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 0);
    check("tp_sw_readback", last_rdata, 32'h1234_5678);
    do_req(1'b0, 2'b10, 1'b0, 32'h22, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 0);

    reset_abort_test();
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 0);
    check("rst_word5_load", last_rdata, 32'h8844_ABF0);

    b2b_test();

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h0000_0FFC + $urandom_range(0, 7);
      else             a = $urandom_range(0, 255);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
